// File: rtl/fetch_stage.sv
// fetch_stage: PC/instruction fetch with IF/ID pipeline latch
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      iload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_dec,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      npc_out,
  output logic             valid_out,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d, npc_q, npc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;
  assign pc_plus4    = pc_q + 32'd4;
  assign iREN        = (state_q == RUN);
  assign halted      = (state_q == HALTED);
  assign iaddr       = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign npc_out     = npc_q;
  assign valid_out   = valid_q;
  assign fetch_count = cnt_q;
  // next state: redirect > halt > stall > hit > miss; HALTED freezes everything
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        pc_d    = {redirect_pc[31:2], 2'b00};
        instr_d = '0;
        valid_d = 1'b0;
      end else if (halt_dec) begin
        state_d = HALTED;
        instr_d = '0;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d  = ihit ? iload : '0;
        valid_d  = ihit;
        pc_out_d = ihit ? pc_q : pc_out_q;
        npc_d    = ihit ? pc_plus4 : npc_q;
        pc_d     = ihit ? pc_plus4 : pc_q;
        cnt_d    = ihit ? cnt_q + CNT_W'(1) : cnt_q;
      end
    end
  end
  // state, PC and IF/ID latch registers with asynchronous reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      pc_q     <= PC_INIT;
      instr_q  <= '0;
      pc_out_q <= '0;
      npc_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch, directly upstream of the decode/control stage.
- Owns the PC and issues instruction reads to the instruction cache (iREN/iaddr/ihit/iload).
- Registers the fetched word with its PC and PC+4 into the IF/ID latch; the latch's instruction output drives the decoder's instruction input.
- Accepts stall from the hazard unit, redirect (branch/jump/jr) from the execute stage, and halt from decode.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset (low two bits must be 0).
CNT_W, 32, width of the fetched-instruction counter.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  icache returned iload for iaddr this cycle.
iload  in  32  instruction word from icache.
iREN  out  1  instruction read enable.
iaddr  out  32  instruction address (equals PC).
stall  in  1  hazard unit: hold PC and IF/ID latch.
redirect_valid  in  1  execute stage: taken branch/jump/jr; squash fetch.
redirect_pc  in  32  new PC target.
halt_dec  in  1  decode has decoded HALT from the current IF/ID latch contents.
instr_out  out  32  IF/ID latched instruction (to decoder).
pc_out  out  32  PC of the latched instruction.
npc_out  out  32  pc_out + 4.
valid_out  out  1  latch holds a real instruction (0 = bubble).
halted  out  1  fetch permanently stopped.
fetch_count  out  CNT_W  number of instructions latched with valid=1.

Behaviour:
- Reset (nRST low, asynchronous, any state):
  - pc = PC_INIT; state = RUN.
  - instr_out = 0; pc_out = 0; npc_out = 0; valid_out = 0.
  - halted = 0; fetch_count = 0.
- States: RUN and HALTED.
  - iREN = 1 in RUN, 0 in HALTED (combinational from state).
  - iaddr = pc at all times.
- RUN, per rising edge; priority from highest to lowest:
  - 1. redirect_valid=1:
    - pc <= {redirect_pc[31:2], 2'b00}.
    - Latch loads bubble: instr_out=0, valid_out=0; pc_out/npc_out hold.
    - Overrides stall, ihit and halt_dec. Any in-flight ihit is discarded and that word is not latched.
  - 2. halt_dec=1:
    - state <= HALTED; latch loads bubble; pc holds.
    - This takes effect even when stall=1.
  - 3. stall=1:
    - pc and the whole latch hold.
    - An ihit in this cycle is ignored; the same address is re-requested.
  - 4. ihit=1:
    - instr_out <= iload; pc_out <= pc; npc_out <= pc+4; valid_out <= 1.
    - pc <= pc+4; fetch_count <= fetch_count+1.
  - 5. ihit=0: latch loads bubble (valid_out=0, instr_out=0); pc holds.
- HALTED:
  - pc, pc_out and npc_out frozen; instr_out=0; valid_out=0; halted=1.
  - redirect_valid, stall and ihit are all ignored.
  - The only exit is nRST.
- Arithmetic:
  - pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - fetch_count wraps modulo 2^CNT_W.
- Latency: one cycle from ihit to instr_out/valid_out.
- Throughput: one instruction per cycle while ihit=1 and no stall/redirect.

Test Plan:
- Reset then streaming: PC_INIT=0, ihit=1 each cycle with iload=0x20010005, 0x20020003, 0x00221820 -> iaddr sequence 0,4,8,C; instr_out follows one cycle later with pc_out 0,4,8 and npc_out 4,8,C; fetch_count=3; iREN=1 throughout.
- Cache miss: ihit=0 for 3 cycles at iaddr=0x10, then ihit=1 with iload=0x8C430000 -> valid_out=0 for 3 cycles, iaddr stays 0x10, then instr_out=0x8C430000 with pc_out=0x10 and npc_out=0x14.
- Stall: latch holds 0x00430820 at pc_out=0x20; stall=1 for 2 cycles with ihit=1 -> latch unchanged, iaddr stays 0x24, fetch_count unchanged; on release the next ihit latches pc_out=0x24.
- Redirect vs stall/halt: stall=1, halt_dec=1 and redirect_valid=1 with redirect_pc=0x0000_0103 in the same cycle -> pc=0x100, valid_out=0, state stays RUN (halted=0).
- Halt: halt_dec=1 with stall=0 -> next cycle halted=1 and iREN=0; a later redirect_valid=1 to 0x40 is ignored (iaddr unchanged); an asynchronous nRST pulse mid-cycle returns iaddr=PC_INIT and halted=0 without waiting for a clock edge.
- Wrap: redirect to 0xFFFF_FFFC, then ihit=1 -> npc_out=0 and iaddr=0.
